// File: rtl/del_meas_pkg.sv
// Shared types and helpers for the delay measurement engine and its channels.
package del_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Samples up to MAG_W bits are sign-extended to this width before taking magnitude.
  localparam int MAG_W = 32;

  // Reported result for a channel that never saw the pulse; sliced to CNT_W.
  localparam logic [MAG_W-1:0] RES_ONES = '1;

  // One extra bit so the most negative input has a representable magnitude.
  function automatic logic [MAG_W:0] mag(input logic signed [MAG_W-1:0] v);
    logic [MAG_W:0] w;
    w = {v[MAG_W-1], v};
    return w[MAG_W] ? ((~w) + {{MAG_W{1'b0}}, 1'b1}) : w;
  endfunction

endpackage

// File: rtl/del_meas_chan.sv
// One ADC channel: threshold detector plus latched arrival count / timeout flag.
module del_meas_chan
  import del_meas_pkg::*;
#(
  parameter int NUM_BITS = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [NUM_BITS-1:0] sample,
  input  logic [NUM_BITS-1:0] thresh,
  input  logic [CNT_W-1:0]    cnt,
  input  logic                tmo,
  output logic                hit_now,
  output logic                hit,
  output logic [CNT_W-1:0]    result,
  output logic                ch_timeout
);

  logic signed [MAG_W-1:0] ext;
  logic [MAG_W:0]          sample_mag;

  assign ext        = MAG_W'(signed'(sample));
  assign sample_mag = mag(ext);
  assign hit_now    = en && !hit && (sample_mag > (MAG_W + 1)'(thresh));

  // A real arrival in the timeout cycle wins over the timeout marking.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hit        <= 1'b0;
      result     <= '0;
      ch_timeout <= 1'b0;
    end else if (hit_now) begin
      hit    <= 1'b1;
      result <= cnt;
    end else if (tmo && !hit) begin
      hit        <= 1'b1;
      result     <= RES_ONES[CNT_W-1:0];
      ch_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/del_meas_engine.sv
// Calibration pulse generator and per-channel arrival timer for pipeline delay measurement.
module del_meas_engine
  import del_meas_pkg::*;
#(
  parameter int NUM_BITS = 16,
  parameter int NUM_DAC  = 3,
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_DAC-1:0]           dac_sel,
  input  logic [NUM_BITS-1:0]          pulse_val,
  input  logic [7:0]                   pulse_len,
  input  logic [NUM_BITS-1:0]          thresh,
  input  logic [CNT_W-1:0]             timeout,
  output logic [NUM_DAC*NUM_BITS-1:0]  dac_out,
  output logic [NUM_DAC-1:0]           dac_valid,
  input  logic [NUM_CH*NUM_BITS-1:0]   adc_in,
  input  logic [NUM_CH-1:0]            adc_valid,
  output logic                         adc_run,
  output logic [NUM_CH*CNT_W-1:0]      result,
  output logic [NUM_CH-1:0]            ch_timeout,
  output logic                         busy,
  output logic                         done
);

  // Keeping the limit one below all-ones means cnt can never wrap before the timeout cycle.
  localparam logic [CNT_W-1:0] TMO_MAX = {{(CNT_W - 1){1'b1}}, 1'b0};

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            tmo_lat;
  logic [7:0]                  plen_left;
  logic                        active;
  logic                        clr;
  logic                        tmo_hit;
  logic                        all_hit;
  logic [NUM_CH-1:0]           hit;
  logic [NUM_CH-1:0]           hit_now;
  logic [CNT_W-1:0]            tmo_eff;
  logic [7:0]                  len_eff;
  logic [NUM_DAC*NUM_BITS-1:0] pulse_word;

  assign active  = (state == ST_PULSE) || (state == ST_WAIT);
  assign clr     = (state == ST_IDLE) && start;
  assign tmo_hit = active && (cnt == tmo_lat);
  assign all_hit = &(hit | hit_now);

  always_comb begin
    tmo_eff = timeout;
    if (timeout == '0) tmo_eff = CNT_W'(1);
    else if (timeout > TMO_MAX) tmo_eff = TMO_MAX;
    len_eff = (pulse_len == 8'd0) ? 8'd1 : pulse_len;
    pulse_word = '0;
    for (int k = 0; k < NUM_DAC; k++) begin
      pulse_word[k*NUM_BITS +: NUM_BITS] = dac_sel[k] ? pulse_val : '0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    del_meas_chan #(
      .NUM_BITS(NUM_BITS),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .en        (active && adc_valid[i]),
      .sample    (adc_in[i*NUM_BITS +: NUM_BITS]),
      .thresh    (thresh),
      .cnt       (cnt),
      .tmo       (tmo_hit),
      .hit_now   (hit_now[i]),
      .hit       (hit[i]),
      .result    (result[i*CNT_W +: CNT_W]),
      .ch_timeout(ch_timeout[i])
    );
  end

  // dac_out holds the masked pulse word captured at start, so no separate select/value latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tmo_lat   <= '0;
      plen_left <= 8'd0;
      dac_out   <= '0;
      dac_valid <= '0;
      adc_run   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_PULSE;
            cnt       <= CNT_W'(1);
            tmo_lat   <= tmo_eff;
            plen_left <= len_eff;
            dac_out   <= pulse_word;
            dac_valid <= '1;
            adc_run   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_PULSE, ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (all_hit || tmo_hit) begin
            state   <= ST_DONE;
            dac_out <= '0;
            adc_run <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (state == ST_PULSE) begin
            if (plen_left == 8'd1) begin
              state   <= ST_WAIT;
              dac_out <= '0;
            end else begin
              plen_left <= plen_left - 8'd1;
            end
          end
        end
        ST_DONE: begin
          if (!start) begin
            state     <= ST_IDLE;
            dac_valid <= '0;
            done      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_del_meas_engine.sv
// Bench for del_meas_engine: table-driven ADC stimulus, reference arrival model, result scoreboard.
module tb_del_meas_engine;

  localparam int NB  = 16;
  localparam int ND  = 3;
  localparam int NC  = 2;
  localparam int CW  = 16;
  localparam int TAB = 300;
  localparam int EW  = NC + NC * CW;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ND-1:0]      dac_sel;
  logic [NB-1:0]      pulse_val;
  logic [7:0]         pulse_len;
  logic [NB-1:0]      thresh;
  logic [CW-1:0]      timeout;
  logic [ND*NB-1:0]   dac_out;
  logic [ND-1:0]      dac_valid;
  logic [NC*NB-1:0]   adc_in;
  logic [NC-1:0]      adc_valid;
  logic               adc_run;
  logic [NC*CW-1:0]   result;
  logic [NC-1:0]      ch_timeout;
  logic               busy;
  logic               done;

  int vectors = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];

  // ADC stimulus per channel, indexed by the cnt value of the cycle it is presented in.
  logic signed [NB-1:0] stim_s [NC][TAB];
  logic                 stim_v [NC][TAB];

  always #5 clk = ~clk;

  del_meas_engine #(
    .NUM_BITS(NB), .NUM_DAC(ND), .NUM_CH(NC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dac_sel(dac_sel), .pulse_val(pulse_val),
    .pulse_len(pulse_len), .thresh(thresh), .timeout(timeout), .dac_out(dac_out),
    .dac_valid(dac_valid), .adc_in(adc_in), .adc_valid(adc_valid), .adc_run(adc_run),
    .result(result), .ch_timeout(ch_timeout), .busy(busy), .done(done)
  );

  task automatic fill_noise(input logic [NB-1:0] th);
    for (int i = 0; i < NC; i++) begin
      for (int k = 0; k < TAB; k++) begin
        int n;
        n = int'($urandom_range(2 * int'(th), 0)) - int'(th);
        stim_s[i][k] = NB'(n);
        stim_v[i][k] = 1'($urandom_range(1, 0));
      end
    end
  endtask

  task automatic run_meas(input logic [ND-1:0] sel, input logic [NB-1:0] val,
                          input logic [7:0] len, input logic [NB-1:0] th,
                          input logic [CW-1:0] tmo, input int restart_at, input bit hold_start);
    int len_e, tmo_e, end_k, m;
    bit all_h;
    int hitk [NC];
    logic [ND*NB-1:0] pw, exp_dac;
    logic [EW-1:0] exp_w, part;
    len_e = (len == 8'd0) ? 1 : int'(len);
    tmo_e = (tmo == '0) ? 1 : ((int'(tmo) > 65534) ? 65534 : int'(tmo));
    all_h = 1'b1;
    end_k = 0;
    exp_w = '0;
    for (int i = 0; i < NC; i++) begin
      hitk[i] = 0;
      for (int k = 1; k <= tmo_e; k++) begin
        if (hitk[i] == 0 && stim_v[i][k]) begin
          m = int'(stim_s[i][k]);
          if (m < 0) m = -m;
          if (m > int'(th)) hitk[i] = k;
        end
      end
      if (hitk[i] == 0) all_h = 1'b0;
      if (hitk[i] > end_k) end_k = hitk[i];
      exp_w[i*CW +: CW] = (hitk[i] != 0) ? CW'(hitk[i]) : {CW{1'b1}};
      exp_w[NC*CW + i]  = (hitk[i] == 0);
    end
    if (!all_h) end_k = tmo_e;
    for (int k = 0; k < ND; k++) pw[k*NB +: NB] = sel[k] ? val : '0;
    exp_q.push_back(exp_w);

    @(negedge clk);
    dac_sel = sel; pulse_val = val; pulse_len = len; thresh = th; timeout = tmo;
    adc_in = '0; adc_valid = '0; start = 1'b1;

    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (restart_at != 0 && k == restart_at) start = 1'b1;
      if (restart_at != 0 && k == restart_at + 2) start = 1'b0;
      vectors++;
      if ({busy, adc_run, done, dac_valid} !== {3'b110, {ND{1'b1}}}) begin
        miscompares++;
        $display("FAIL run_status cnt=%0d got %b want %b", k, {busy, adc_run, done, dac_valid}, {3'b110, {ND{1'b1}}});
      end
      exp_dac = (k <= len_e) ? pw : '0;
      vectors++;
      if (dac_out !== exp_dac) begin
        miscompares++;
        $display("FAIL dac_out cnt=%0d got %h want %h", k, dac_out, exp_dac);
      end
      part = '0;
      for (int i = 0; i < NC; i++)
        if (hitk[i] != 0 && hitk[i] < k) part[i*CW +: CW] = CW'(hitk[i]);
      vectors++;
      if ({ch_timeout, result} !== part) begin
        miscompares++;
        $display("FAIL partial_result cnt=%0d got %h want %h", k, {ch_timeout, result}, part);
      end
      for (int i = 0; i < NC; i++) begin
        adc_in[i*NB +: NB] = stim_s[i][k];
        adc_valid[i] = stim_v[i][k];
      end
    end

    @(negedge clk);
    adc_in = '0; adc_valid = '0;
    vectors++;
    if ({busy, adc_run, done, dac_valid, dac_out} !== {3'b001, {ND{1'b1}}, {(ND*NB){1'b0}}}) begin
      miscompares++;
      $display("FAIL done_status got %b dac %h want done=1 busy=0 run=0 valid=all dac=0",
               {busy, adc_run, done, dac_valid}, dac_out);
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty got empty queue want one entry");
    end else begin
      exp_w = exp_q.pop_front();
      if ({ch_timeout, result} !== exp_w) begin
        miscompares++;
        $display("FAIL final_result got %h want %h", {ch_timeout, result}, exp_w);
      end
    end
    if (hold_start) begin
      start = 1'b1;
      repeat (3) begin
        @(negedge clk);
        vectors++;
        if ({busy, done, adc_run} !== 3'b010) begin
          miscompares++;
          $display("FAIL done_hold got busy,done,run=%b want 010", {busy, done, adc_run});
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, adc_run, done, dac_valid, dac_out, ch_timeout, result} !==
        {3'b000, {ND{1'b0}}, {(ND*NB){1'b0}}, exp_w}) begin
      miscompares++;
      $display("FAIL idle_hold got status %b dac %h res %h want 0 0 %h",
               {busy, adc_run, done, dac_valid}, dac_out, {ch_timeout, result}, exp_w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dac_sel = '0; pulse_val = '0; pulse_len = '0;
    thresh = '0; timeout = '0; adc_in = '0; adc_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({dac_out, dac_valid, adc_run, result, ch_timeout, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0", {dac_out, dac_valid, adc_run, result, ch_timeout, busy, done});
    end
    @(negedge clk);
    vectors++;
    if ({busy, done, dac_valid} !== '0) begin
      miscompares++;
      $display("FAIL idle_quiet got %b want 0", {busy, done, dac_valid});
    end
  endtask

  task automatic test_basic();
    fill_noise(16'd100);
    stim_s[0][7] = 16'sd500;   stim_v[0][7] = 1'b1;
    stim_s[1][12] = -16'sd700; stim_v[1][12] = 1'b1;
    run_meas(3'b111, 16'h1234, 8'd1, 16'd100, 16'd255, 0, 1'b0);
  endtask

  task automatic test_most_negative();
    fill_noise(16'd32767);
    for (int i = 0; i < NC; i++) begin
      stim_s[i][5] = 16'sh8000; stim_v[i][5] = 1'b1;
    end
    run_meas(3'b101, 16'h7fff, 8'd3, 16'd32767, 16'd255, 0, 1'b0);
  endtask

  task automatic test_timeout();
    fill_noise(16'd100);
    stim_s[1][20] = 16'sd150; stim_v[1][20] = 1'b1;
    run_meas(3'b001, 16'h0100, 8'd2, 16'd100, 16'd30, 0, 1'b0);
  endtask

  task automatic test_dac_sel();
    fill_noise(16'd50);
    stim_s[0][6] = 16'sd60;  stim_v[0][6] = 1'b1;
    stim_s[1][9] = -16'sd51; stim_v[1][9] = 1'b1;
    run_meas(3'b010, 16'h5a5a, 8'd4, 16'd50, 16'd255, 2, 1'b0);
  endtask

  task automatic test_thresh_valid();
    fill_noise(16'd100);
    stim_s[0][3] = 16'sd100;    stim_v[0][3] = 1'b1;
    stim_s[0][4] = -16'sd100;   stim_v[0][4] = 1'b1;
    stim_s[0][5] = 16'sd300;    stim_v[0][5] = 1'b0;
    stim_s[0][6] = 16'sd300;    stim_v[0][6] = 1'b1;
    stim_s[1][8] = 16'sh8000;   stim_v[1][8] = 1'b0;
    stim_s[1][9] = 16'sd101;    stim_v[1][9] = 1'b1;
    run_meas(3'b100, 16'hffff, 8'd2, 16'd100, 16'd255, 0, 1'b0);
  endtask

  task automatic test_zero_params();
    fill_noise(16'd100);
    stim_s[0][1] = 16'sd200; stim_v[0][1] = 1'b1;
    run_meas(3'b011, 16'h0042, 8'd0, 16'd100, 16'd0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill_noise(16'd200);
    stim_s[0][$urandom_range(40, 2)] = 16'sd900;  stim_v[0][10] = 1'b1;
    stim_s[1][$urandom_range(60, 2)] = -16'sd900;
    for (int k = 2; k <= 60; k++) if (stim_s[1][k] == -16'sd900) stim_v[1][k] = 1'b1;
    for (int k = 2; k <= 40; k++) if (stim_s[0][k] == 16'sd900) stim_v[0][k] = 1'b1;
    run_meas(ND'($urandom_range(7, 0)), NB'($urandom), 8'($urandom_range(6, 1)), 16'd200, 16'd50, 0, 1'b1);
    fill_noise(16'd80);
    stim_s[0][$urandom_range(30, 1)] = -16'sd81;
    stim_s[1][$urandom_range(30, 1)] = 16'sd4000;
    for (int k = 1; k <= 30; k++) begin
      if (stim_s[0][k] == -16'sd81) stim_v[0][k] = 1'b1;
      if (stim_s[1][k] == 16'sd4000) stim_v[1][k] = 1'b1;
    end
    run_meas(ND'($urandom_range(7, 0)), NB'($urandom), 8'($urandom_range(10, 0)), 16'd80, 16'd40, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    fill_noise(16'd100);
    @(negedge clk);
    dac_sel = 3'b111; pulse_val = 16'h0777; pulse_len = 8'd2; thresh = 16'd100;
    timeout = 16'd255; start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      for (int i = 0; i < NC; i++) begin
        adc_in[i*NB +: NB] = stim_s[i][k];
        adc_valid[i] = stim_v[i][k];
      end
      if (k == 9) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    adc_in = '0; adc_valid = '0;
    vectors++;
    if ({dac_out, dac_valid, adc_run, result, ch_timeout, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset got %h want 0", {dac_out, dac_valid, adc_run, result, ch_timeout, busy, done});
    end
    fill_noise(16'd100);
    stim_s[0][3] = 16'sd400; stim_v[0][3] = 1'b1;
    stim_s[1][4] = 16'sd400; stim_v[1][4] = 1'b1;
    run_meas(3'b001, 16'h0777, 8'd2, 16'd100, 16'd255, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_most_negative();
    test_timeout();
    test_dac_sel();
    test_thresh_valid();
    test_zero_params();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
